// File: rtl/xdemux4_pkg.sv
// Shared definitions for the xdemux4 stream distributor: state encoding,
// default widths and configuration field offsets.
package xdemux4_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 10;
  localparam int NCH        = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  // Bit offsets of the FU fields within the packed configuration word.
  localparam int CFG_SEL_OFF    = 0;
  localparam int CFG_RR_EN_OFF  = 2;
  localparam int CFG_DELAY_OFF  = 3;
  localparam int CFG_LENGTH_OFF = CFG_DELAY_OFF + DEF_CNT_W;
  localparam int CFG_W          = CFG_LENGTH_OFF + DEF_CNT_W;

  function automatic logic [NCH-1:0] onehot4(input logic [1:0] ch);
    return 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/xdemux4_ctrl.sv
// Sequencer for xdemux4: delay/length counters, run FSM and target channel.
// Latency: first capture enable delay+1 cycles after run; no backpressure, run always wins.
// Backpressure: none; a run pulse in any state restarts the sequence.
module xdemux4_ctrl
  import xdemux4_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [1:0]       sel,
  input  logic             rr_en,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] length,
  output logic             done,
  output logic             cap_en,
  output logic [1:0]       target
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] dly_cnt;
  logic [CNT_W-1:0] len_cnt;
  logic             rr_q;

  assign done   = (state == IDLE);
  // A run pulse pre-empts the capture that would otherwise happen on this edge.
  assign cap_en = (state == ACTIVE) && !run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      dly_cnt <= '0;
      len_cnt <= '0;
      rr_q    <= 1'b0;
      target  <= 2'd0;
    end else if (run) begin
      if (length != '0) begin
        rr_q    <= rr_en;
        target  <= sel;
        len_cnt <= length;
        dly_cnt <= delay;
        state   <= (delay == '0) ? ACTIVE : WAIT;
      end else begin
        state <= IDLE;
      end
    end else begin
      case (state)
        WAIT: begin
          dly_cnt <= dly_cnt - ONE;
          if (dly_cnt == ONE) state <= ACTIVE;
        end
        ACTIVE: begin
          len_cnt <= len_cnt - ONE;
          if (rr_q) target <= target + 2'd1;
          if (len_cnt == ONE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/xdemux4.sv
// Distributes consecutive in0 samples onto four registered outputs, fixed or round-robin.
// Latency: data and one-hot strobe appear one cycle after the capture edge.
// Backpressure: none; outputs are strobed and consumers must accept every word.
module xdemux4
  import xdemux4_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              done,
  input  logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [NCH-1:0]    out_vld,
  input  logic [1:0]        sel,
  input  logic              rr_en,
  input  logic [CNT_W-1:0]  delay,
  input  logic [CNT_W-1:0]  length
);

  logic              cap_en;
  logic [1:0]        target;
  logic [DATA_W-1:0] data_q [NCH];

  xdemux4_ctrl #(.CNT_W(CNT_W)) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .sel    (sel),
    .rr_en  (rr_en),
    .delay  (delay),
    .length (length),
    .done   (done),
    .cap_en (cap_en),
    .target (target)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) data_q[i] <= '0;
      out_vld <= '0;
    end else if (cap_en) begin
      data_q[target] <= in0;
      out_vld        <= onehot4(target);
    end else begin
      out_vld <= '0;
    end
  end

  assign out0 = data_q[0];
  assign out1 = data_q[1];
  assign out2 = data_q[2];
  assign out3 = data_q[3];

endmodule

// File: tb/tb_xdemux4.sv
// Bench for xdemux4: directed scenarios plus random run/config traffic, checked
// against a model that schedules captures by edge index.
module tb_xdemux4;

  logic        clk;
  logic        rst;
  logic        run;
  logic        done;
  logic [31:0] in0;
  logic [31:0] out0, out1, out2, out3;
  logic [3:0]  out_vld;
  logic [1:0]  sel;
  logic        rr_en;
  logic [9:0]  delay;
  logic [9:0]  length;

  int compared;
  int mismatched;

  xdemux4 dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .done    (done),
    .in0     (in0),
    .out0    (out0),
    .out1    (out1),
    .out2    (out2),
    .out3    (out3),
    .out_vld (out_vld),
    .sel     (sel),
    .rr_en   (rr_en),
    .delay   (delay),
    .length  (length)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: an operation is a window of edge indices [m_start, m_end].
  logic [31:0] m_out [4];
  logic [3:0]  m_vld;
  bit          m_busy;
  int          m_start, m_end, m_sel, n;
  bit          m_rr;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_out[i] = '0;
    m_vld  = '0;
    m_busy = 0;
    n      = 0;
  endtask

  task automatic model_edge(input logic r, input logic [1:0] s, input logic rr,
                            input logic [9:0] d, input logic [9:0] l,
                            input logic [31:0] x);
    int ch;
    m_vld = '0;
    if (r) begin
      if (l != 0) begin
        m_busy  = 1;
        m_start = n + int'(d) + 1;
        m_end   = m_start + int'(l) - 1;
        m_sel   = int'(s);
        m_rr    = rr;
      end else begin
        m_busy = 0;
      end
    end else if (m_busy && n >= m_start && n <= m_end) begin
      ch        = (m_sel + (m_rr ? (n - m_start) : 0)) % 4;
      m_out[ch] = x;
      m_vld     = 4'(1 << ch);
      if (n == m_end) m_busy = 0;
    end
    n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out0", out0, m_out[0]);
    chk("out1", out1, m_out[1]);
    chk("out2", out2, m_out[2]);
    chk("out3", out3, m_out[3]);
    chk("out_vld", 32'(out_vld), 32'(m_vld));
    chk("done", 32'(done), 32'(!m_busy));
  endtask

  task automatic step(input logic r, input logic [1:0] s, input logic rr,
                      input logic [9:0] d, input logic [9:0] l, input logic [31:0] x);
    run = r; sel = s; rr_en = rr; delay = d; length = l; in0 = x;
    @(posedge clk);
    model_edge(r, s, rr, d, l, x);
    #1;
    check_all();
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    model_reset();
    rst = 1'b0; run = 1'b0; sel = '0; rr_en = 1'b0; delay = '0; length = '0; in0 = '0;
    #2;
    check_all();
    #10 rst = 1'b1;
    step(0, 0, 0, 0, 0, 32'h0);
    check_all();

    // Fixed steering to channel 2.
    step(1, 2, 0, 0, 3, 32'h0);
    step(0, 0, 0, 0, 0, 32'hA);
    step(0, 0, 0, 0, 0, 32'hB);
    step(0, 0, 0, 0, 0, 32'hC);
    chk("fixed_out2", out2, 32'hC);
    chk("fixed_out0", out0, 32'h0);
    step(0, 0, 0, 0, 0, 32'hD);

    // Round-robin starting at channel 3 wraps to 0.
    step(1, 3, 1, 0, 5, 32'h0);
    for (int i = 1; i <= 5; i++) step(0, 0, 0, 0, 0, 32'(i));
    chk("rr_out3", out3, 32'd5);
    chk("rr_out0", out0, 32'd2);
    chk("rr_out2", out2, 32'd4);
    step(0, 0, 0, 0, 0, 32'h0);

    // Delay of 4: capture samples the value driven five edges after run.
    for (int k = 0; k < 7; k++) step(k == 0, 0, 0, 4, 1, 32'h10 + 32'(k));
    chk("delay_out0", out0, 32'h15);

    // Zero length is ignored.
    step(1, 1, 1, 0, 0, 32'hFF);
    step(0, 0, 0, 0, 0, 32'hEE);

    // Restart mid-operation after two of four samples.
    step(1, 0, 0, 0, 4, 32'h0);
    step(0, 0, 0, 0, 0, 32'h21);
    step(0, 0, 0, 0, 0, 32'h22);
    step(1, 1, 0, 0, 2, 32'h23);
    step(0, 0, 0, 0, 0, 32'h24);
    step(0, 0, 0, 0, 0, 32'h25);
    chk("restart_out0", out0, 32'h22);
    chk("restart_out1", out1, 32'h25);
    step(0, 0, 0, 0, 0, 32'h26);

    // Random traffic, including restarts and mid-run config changes.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) == 0, 2'($urandom), 1'($urandom),
           10'($urandom_range(0, 5)), 10'($urandom_range(0, 6)), $urandom);
    end

    // Asynchronous reset while ACTIVE.
    step(1, 1, 1, 0, 8, 32'h0);
    step(0, 0, 0, 0, 0, 32'h31);
    step(0, 0, 0, 0, 0, 32'h32);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk) rst = 1'b1;
    step(0, 0, 0, 0, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/xdemux4.md
Name: xdemux4

Overview:
- Versat functional unit that is the distributing counterpart of the 4:1 selector.
- Takes one input data stream, in0, and steers a programmed number of consecutive samples onto one of four registered outputs.
- Steering is either a fixed channel or round-robin across channels.
- Sits in the data engine alongside the other FUs; controlled by the common run/done pair and static configuration inputs.

Parameters:
- DATA_W, 32, width of in0 and of each output.
- CNT_W, 10, width of the delay and length configuration fields and their internal counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- run  in  1  single-cycle start pulse; latches configuration
- done  out  1  high when idle
- in0  in  DATA_W  input sample stream
- out0  out  DATA_W  channel 0 data, registered
- out1  out  DATA_W  channel 1 data, registered
- out2  out  DATA_W  channel 2 data, registered
- out3  out  DATA_W  channel 3 data, registered
- out_vld  out  4  per-channel one-cycle strobe; bit i marks a new word on out i
- sel  in  2  fixed target channel, or start channel in round-robin mode
- rr_en  in  1  1 = round-robin steering, 0 = fixed steering
- delay  in  CNT_W  idle cycles between run and the first capture
- length  in  CNT_W  number of samples to distribute

Behaviour:
- Reset (rst low, asynchronous): out0..out3 = 0, out_vld = 0, state = IDLE, done = 1, all counters and latched configuration = 0.
- States are IDLE, WAIT and ACTIVE. done = (state == IDLE), decoded from registered state.
- IDLE:
  - On a clock edge with run=1 and length!=0: latch sel, rr_en, delay and length; target <= sel.
  - Next state is ACTIVE if delay==0, else WAIT with dly_cnt <= delay.
  - run=1 with length==0 is ignored; done stays 1.
- WAIT: dly_cnt decrements every cycle. When dly_cnt==1, go to ACTIVE. No captures in WAIT; out_vld = 0.
- ACTIVE, every cycle:
  - out[target] <= in0.
  - out_vld <= one-hot(target); non-target outputs hold their value.
  - len_cnt decrements.
  - If rr_en, target <= target+1 modulo 4 (3 wraps to 0); otherwise target holds.
  - When len_cnt==1, this is the last capture; next state is IDLE.
- Latency:
  - The first capture samples in0 on edge run_edge + delay + 1.
  - Captured data and its strobe appear on the outputs the cycle after the capture edge.
  - done rises the cycle after the last capture, together with the last out_vld strobe.
- out_vld is cleared on every cycle that does not capture.
- Outputs keep their last value indefinitely in IDLE.
- run while in WAIT or ACTIVE restarts the operation:
  - Configuration is re-latched and target <= sel.
  - The next state follows the IDLE rule, except that length==0 sends the unit to IDLE.
  - The restart takes priority over the current cycle's capture: no capture on that edge.
- Configuration inputs are ignored except on run edges; changing them mid-run has no effect.
- Counters are CNT_W bits wide. Maximum delay and length are 2^CNT_W-1; no wrap handling is required beyond that range.

Decomposition:
- Shared package / xversat.vh header holds:
  - the state encodings (IDLE=2'd0, WAIT=2'd1, ACTIVE=2'd2);
  - the default DATA_W and CNT_W values;
  - the FU configuration field offsets for sel, rr_en, delay and length.
- One natural sub-module: xdemux4_ctrl, holding the FSM, the delay and length counters and the target channel register. It outputs a capture enable and the 2-bit target.
- The top-level module holds the four output registers and the strobe register.

Test Plan:
- Reset, then release: out0..3 = 0, out_vld = 0, done = 1. Assert rst low mid-ACTIVE: all outputs clear immediately, without waiting for a clock edge.
- Fixed mode: sel=2, rr_en=0, delay=0, length=3, in0 = 0xA, 0xB, 0xC on the three cycles after run.
  - out2 takes 0xA, 0xB, 0xC; out_vld = 4'b0100 for 3 cycles.
  - out0, out1 and out3 stay 0.
  - done is low for exactly 3 cycles.
- Round-robin wrap: sel=3, rr_en=1, delay=0, length=5, in0 = 1..5.
  - Final values: out3=5, out0=2, out1=3, out2=4.
  - out_vld sequence: 1000, 0001, 0010, 0100, 1000.
- Delay: delay=4, length=1, sel=0, in0 counting up by 1 each cycle from 0x10 on the run edge. The capture edge is run+5, so out0 = 0x15; no strobes before that.
- length=0 with run: done stays 1, no strobes, outputs unchanged.
- Restart: during ACTIVE with sel=0 and 2 of 4 samples done, pulse run with sel=1, length=2, delay=0.
  - There is no capture on the run edge.
  - The next two captures go to out1 only; out0 keeps its second sample.
  - done rises after the second capture.
